// File: rtl/ccff_chain_loader_if.sv
// Stream and chain-side signal bundle for the CCFF chain loader.
// The slave modport is the loader; the master modport is the config port plus chain.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              ccff_shift_en;
  logic              busy;
  logic              done;

  modport master (
    output start, s_data, s_valid, m_ready, ccff_tail,
    input  s_ready, m_data, m_valid, ccff_head, ccff_shift_en, busy, done
  );

  modport slave (
    input  start, s_data, s_valid, m_ready, ccff_tail,
    output s_ready, m_data, m_valid, ccff_head, ccff_shift_en, busy, done
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes configuration words into the CCFF chain head while assembling the
// bits leaving the chain tail into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8
) (
  input logic             prog_clk,
  input logic             prog_reset,
  ccff_chain_loader_if.slave bus
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] asm_word, asm_nxt;
  logic [WORD_W-1:0] rb_data;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     idx;
  logic              rb_valid, done_r;
  logic              hold_free, last_bit, word_end, m_take, accept, s_ready, shift_en;

  // Input and readback words share boundaries, so one index serves both.
  always_comb begin
    hold_free = !rb_valid || bus.m_ready;
    last_bit  = (bit_cnt == LAST_BIT);
    word_end  = (idx == LAST_IDX) || last_bit;
    m_take    = rb_valid && bus.m_ready;
    asm_nxt   = asm_word | (WORD_W'(bus.ccff_tail) << idx);
    s_ready   = 1'b0;
    shift_en  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = FETCH;
      FETCH: begin
        s_ready = 1'b1;
        if (bus.s_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = hold_free;
        if (hold_free && last_bit)      state_nxt = DRAIN;
        else if (hold_free && word_end) state_nxt = FETCH;
      end
      DRAIN: if (m_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    accept = s_ready && bus.s_valid;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      bit_cnt  <= '0;
      idx      <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state == DRAIN) && m_take;
      if (state == IDLE && bus.start) begin
        bit_cnt <= '0;
        idx     <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + CW'(1);
        idx     <= word_end ? '0 : idx + IW'(1);
      end
      // A completed word may replace one being accepted in the same cycle.
      if (shift_en && word_end) begin
        rb_data  <= asm_nxt;
        rb_valid <= 1'b1;
      end else if (m_take) begin
        rb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (state == IDLE && bus.start) asm_word <= '0;
    else if (shift_en)              asm_word <= word_end ? '0 : asm_nxt;
    if (accept)        sreg <= bus.s_data;
    else if (shift_en) sreg <= sreg >> 1;
  end

  assign bus.s_ready       = s_ready;
  assign bus.ccff_shift_en = shift_en;
  assign bus.ccff_head     = (state == SHIFT) && sreg[0];
  assign bus.m_data        = rb_data;
  assign bus.m_valid       = rb_valid;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_r;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Drives three loader instances (18, 8 and 1 bit chains) against a model of the
// physical chain and a word-level expectation of chain content and readback.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int M_PLAIN = 0, M_STALL = 1, M_STARVE = 2, M_RAND = 3, M_BUSY = 4, M_ABORT = 5;

  logic        rst, start, s_valid, m_ready, load_chain;
  logic [7:0]  s_data;
  logic [31:0] load_val;
  int          sel;
  logic [31:0] chain [3];
  logic [2:0]  s_ready_w, m_valid_w, head_w, sh_en_w, busy_w, done_w;
  logic [7:0]  m_data_w [3];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic int len_of(input int k);
    return (k == 0) ? 18 : (k == 1) ? 8 : 1;
  endfunction

  function automatic logic [31:0] lmask(input int k);
    return (32'd1 << len_of(k)) - 32'd1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 18 : (g == 1) ? 8 : 1;
    ccff_chain_loader_if #(.WORD_W(8)) bus ();
    assign bus.start     = start && (sel == g);
    assign bus.s_data    = s_data;
    assign bus.s_valid   = s_valid && (sel == g);
    assign bus.m_ready   = m_ready;
    assign bus.ccff_tail = chain[g][0];
    assign s_ready_w[g]  = bus.s_ready;
    assign m_valid_w[g]  = bus.m_valid;
    assign m_data_w[g]   = bus.m_data;
    assign head_w[g]     = bus.ccff_head;
    assign sh_en_w[g]    = bus.ccff_shift_en;
    assign busy_w[g]     = bus.busy;
    assign done_w[g]     = bus.done;
    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(8)) dut (
      .prog_clk  (clk),
      .prog_reset(rst),
      .bus       (bus.slave)
    );
  end

  // Physical chain: head enters at the top bit, tail is bit 0.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (load_chain && sel == k) chain[k] <= load_val & lmask(k);
      else if (sh_en_w[k])        chain[k] <= (chain[k] >> 1) | ({31'd0, head_w[k]} << (len_of(k) - 1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] outs(input int k);
    return 32'({s_ready_w[k], m_valid_w[k], m_data_w[k], head_w[k], sh_en_w[k], busy_w[k], done_w[k]});
  endfunction

  task automatic run_load(input int k, input bit do_pre, input logic [31:0] pre,
                          input logic [31:0] cfg, input int mode);
    int L, nw, wi, cyc, shifts, stall_cyc, starve_cyc, en_bad, last_hs, done_at, ndone;
    logic [7:0]  rb [$];
    logic [31:0] exp_w;
    L = len_of(k); nw = (L + 7) / 8;
    wi = 0; cyc = 0; shifts = 0; stall_cyc = 0; starve_cyc = 0; en_bad = 0;
    last_hs = -10; done_at = -1; ndone = 0;
    sel = k; s_valid = 1'b0; m_ready = 1'b1; start = 1'b0;
    if (do_pre) begin
      load_val = pre; load_chain = 1'b1;
      @(posedge clk); #1 load_chain = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (ndone == 0 && cyc < 500) begin
      s_data  = 8'(cfg >> (8 * wi));
      s_valid = (wi < nw) && !(mode == M_STARVE && wi == 1 && starve_cyc < 5)
                && (mode != M_RAND || $urandom_range(0, 1) == 1);
      m_ready = (mode == M_STALL) ? (stall_cyc >= 10)
              : (mode == M_RAND)  ? ($urandom_range(0, 3) != 0) : 1'b1;
      start   = (mode == M_BUSY) && (shifts < L / 2) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (sh_en_w[k]) begin
        shifts++;
        if (m_valid_w[k] && !m_ready) en_bad++;
        if (!busy_w[k]) en_bad++;
      end
      if (mode == M_STALL && m_valid_w[k] && !m_ready) stall_cyc++;
      if (mode == M_STARVE && wi == 1 && s_ready_w[k] && !s_valid) begin
        starve_cyc++;
        if (sh_en_w[k] || !busy_w[k]) en_bad++;
      end
      if (s_ready_w[k] && s_valid) wi++;
      if (m_valid_w[k] && m_ready) begin rb.push_back(m_data_w[k]); last_hs = cyc; end
      if (done_w[k]) begin ndone++; done_at = cyc; end
      if (mode == M_ABORT && shifts == 7) break;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (mode == M_ABORT) begin
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("abort_shifts", 32'(shifts), 32'd7);
      chk("abort_outputs", outs(k), 32'd0);
      return;
    end
    chk($sformatf("done_seen_k%0d", k), 32'(ndone), 32'd1);
    chk($sformatf("idle_after_done_k%0d", k), 32'(busy_w[k]), 32'd0);
    chk($sformatf("chain_k%0d", k), chain[k], cfg & lmask(k));
    chk($sformatf("shift_count_k%0d", k), 32'(shifts), 32'(L));
    chk($sformatf("rb_count_k%0d", k), 32'(rb.size()), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      exp_w = '0;
      for (int j = 0; j < 8; j++) if (8 * i + j < L) exp_w[j] = pre[8 * i + j];
      chk($sformatf("rb_word%0d_k%0d", i, k), (i < rb.size()) ? 32'(rb[i]) : 32'hDEAD_BEEF, exp_w);
    end
    chk($sformatf("done_timing_k%0d", k), 32'(done_at), 32'(last_hs + 1));
    chk($sformatf("shift_gating_k%0d", k), 32'(en_bad), 32'd0);
    if (mode == M_STALL)  chk("stall_len", 32'(stall_cyc), 32'd10);
    if (mode == M_STARVE) chk("starve_len", 32'(starve_cyc), 32'd5);
  endtask

  initial begin
    logic [31:0] c1;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    load_chain = 1'b0; load_val = '0; sel = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs_k%0d", k), outs(k), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_load(0, 1'b1, 32'h2AAAA, 32'h25AC3, M_PLAIN);
    run_load(0, 1'b1, 32'h2AAAA, 32'h25AC3, M_STALL);
    run_load(0, 1'b1, 32'h2AAAA, 32'h25AC3, M_STARVE);
    run_load(1, 1'b1, $urandom, 32'h0000_00F0, M_PLAIN);
    run_load(2, 1'b1, 32'h0, 32'h0000_00FF, M_PLAIN);
    run_load(2, 1'b1, 32'h1, 32'h0000_00FE, M_PLAIN);
    run_load(0, 1'b1, $urandom, $urandom, M_ABORT);
    run_load(0, 1'b1, $urandom, $urandom, M_PLAIN);
    run_load(0, 1'b1, $urandom, $urandom, M_BUSY);
    c1 = $urandom;
    run_load(0, 1'b1, $urandom, c1, M_PLAIN);
    run_load(0, 1'b0, c1, $urandom, M_PLAIN);
    for (int n = 0; n < 8; n++) run_load(int'($urandom_range(0, 2)), 1'b1, $urandom, $urandom, M_RAND);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
